// File: rtl/mem_bus_pkg.sv
// Shared types for the two-master picorv32-native memory bus arbiter.
package mem_bus_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic        valid;
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } mem_req_t;

  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEADBEEF;

endpackage

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one valid/ready memory port between two masters,
// one transaction at a time, with a watchdog that force-completes a stalled slave.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_valid,
  input  logic        m0_instr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic        m1_instr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic        s_instr,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  output logic        grant,
  output logic        bus_err
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

  arb_state_t    state_q;
  logic          grant_q, grant_d;
  logic          prio_q;
  logic [TW-1:0] timer_q, timer_d;

  mem_req_t req0, req1, sel;
  logic     in_busy, done_c, timeout_c, finish_c;

  // Request mux follows the registered grant
  always_comb begin
    req0 = '{valid: m0_valid, instr: m0_instr, addr: m0_addr, wdata: m0_wdata, wstrb: m0_wstrb};
    req1 = '{valid: m1_valid, instr: m1_instr, addr: m1_addr, wdata: m1_wdata, wstrb: m1_wstrb};
    sel  = grant_q ? req1 : req0;
  end

  // s_ready beats the watchdog when both land on the same cycle
  always_comb begin
    in_busy   = (state_q == BUSY);
    done_c    = in_busy && sel.valid && s_ready;
    timeout_c = in_busy && sel.valid && !s_ready && (timer_q == TLAST);
    finish_c  = done_c || timeout_c;

    s_valid  = in_busy && sel.valid && !timeout_c;
    s_instr  = sel.instr;
    s_addr   = sel.addr;
    s_wdata  = sel.wdata;
    s_wstrb  = sel.wstrb;

    m0_ready = finish_c && !grant_q;
    m1_ready = finish_c && grant_q;
    m0_rdata = timeout_c ? ERR_RDATA : s_rdata;
    m1_rdata = timeout_c ? ERR_RDATA : s_rdata;
    bus_err  = timeout_c;
    grant    = grant_q;

    grant_d  = (m0_valid && m1_valid) ? prio_q : m1_valid;
    timer_d  = (timer_q == '1) ? timer_q : timer_q + TW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      prio_q  <= 1'b0;
      timer_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (m0_valid || m1_valid) begin
            grant_q <= grant_d;
            timer_q <= '0;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (!sel.valid) begin
            state_q <= IDLE;
          end else if (finish_c) begin
            prio_q  <= ~grant_q;
            state_q <= IDLE;
          end else begin
            timer_q <= timer_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed table-driven bench for mem_bus_arbiter with hand-built watchdog and reset sequences.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_valid, m0_instr, m0_ready;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic [3:0]  m0_wstrb;
  logic        m1_valid, m1_instr, m1_ready;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  m1_wstrb;
  logic        s_valid, s_instr, s_ready;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_wstrb;
  logic        grant, bus_err;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.TIMEOUT_CYCLES(8), .ERR_RDATA(32'hDEADBEEF)) dut (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_instr(s_instr), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata),
    .grant(grant), .bus_err(bus_err)
  );

  typedef struct {
    logic        rst, m0v, m1v, srdy;
    logic [31:0] srd;
    logic        sv, gnt, r0, r1, err;
    logic [31:0] rd;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;
  vec_t tbl[24];

  function automatic vec_t mk(logic rst, logic m0v, logic m1v, logic srdy, logic [31:0] srd,
                              logic sv, logic gnt, logic r0, logic r1, logic err, logic [31:0] rd);
    vec_t v;
    v.rst = rst; v.m0v = m0v; v.m1v = m1v; v.srdy = srdy; v.srd = srd;
    v.sv = sv; v.gnt = gnt; v.r0 = r0; v.r1 = r1; v.err = err; v.rd = rd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL vec %0d %s: got %h want %h", n_vec, nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs at negedge, compare outputs before the next posedge
  task automatic apply(input vec_t v);
    @(negedge clk);
    reset = v.rst; m0_valid = v.m0v; m1_valid = v.m1v; s_ready = v.srdy; s_rdata = v.srd;
    #1;
    n_vec++;
    chk("s_valid", 32'(s_valid), 32'(v.sv));
    chk("grant", 32'(grant), 32'(v.gnt));
    chk("m0_ready", 32'(m0_ready), 32'(v.r0));
    chk("m1_ready", 32'(m1_ready), 32'(v.r1));
    chk("bus_err", 32'(bus_err), 32'(v.err));
    if (v.r0) chk("m0_rdata", m0_rdata, v.rd);
    if (v.r1) chk("m1_rdata", m1_rdata, v.rd);
    if (v.sv) begin
      chk("s_addr", s_addr, v.gnt ? 32'h0000_03fc : 32'h0000_0004);
      chk("s_wdata", s_wdata, v.gnt ? 32'h0000_0005 : 32'h0000_0000);
      chk("s_wstrb", 32'(s_wstrb), v.gnt ? 32'hf : 32'h0);
      chk("s_instr", 32'(s_instr), 32'(!v.gnt));
    end
  endtask

  initial begin
    // m0: instruction read of 0x004; m1: store word 5 to 0x3fc
    m0_instr = 1'b1; m0_addr = 32'h0000_0004; m0_wdata = 32'h0; m0_wstrb = 4'b0000;
    m1_instr = 1'b0; m1_addr = 32'h0000_03fc; m1_wdata = 32'h5; m1_wstrb = 4'b1111;
    m0_valid = 1'b0; m1_valid = 1'b0; s_ready = 1'b0; s_rdata = 32'h0;
    reset = 1'b1;
    repeat (2) @(posedge clk);

    // single read, then simultaneous requests, then continuous alternation
    tbl[0]  = mk(0,1,0,0,32'h0,        0,0,0,0,0,32'h0);
    tbl[1]  = mk(0,1,0,0,32'h0,        1,0,0,0,0,32'h0);
    tbl[2]  = mk(0,1,0,1,32'h0000a023, 1,0,1,0,0,32'h0000a023);
    tbl[3]  = mk(0,0,0,0,32'h0,        0,0,0,0,0,32'h0);
    tbl[4]  = mk(1,0,0,0,32'h0,        0,0,0,0,0,32'h0);
    tbl[5]  = mk(0,1,1,0,32'h0,        0,0,0,0,0,32'h0);
    tbl[6]  = mk(0,1,1,1,32'h11,       1,0,1,0,0,32'h11);
    tbl[7]  = mk(0,0,1,0,32'h0,        0,0,0,0,0,32'h0);
    tbl[8]  = mk(0,0,1,1,32'h22,       1,1,0,1,0,32'h22);
    tbl[9]  = mk(0,0,0,0,32'h0,        0,1,0,0,0,32'h0);
    tbl[10] = mk(0,1,1,0,32'h0,        0,1,0,0,0,32'h0);
    tbl[11] = mk(0,1,1,1,32'h30,       1,0,1,0,0,32'h30);
    tbl[12] = mk(0,1,1,0,32'h0,        0,0,0,0,0,32'h0);
    tbl[13] = mk(0,1,1,1,32'h31,       1,1,0,1,0,32'h31);
    tbl[14] = mk(0,1,1,0,32'h0,        0,1,0,0,0,32'h0);
    tbl[15] = mk(0,1,1,1,32'h32,       1,0,1,0,0,32'h32);
    tbl[16] = mk(0,1,1,0,32'h0,        0,0,0,0,0,32'h0);
    tbl[17] = mk(0,1,1,1,32'h33,       1,1,0,1,0,32'h33);
    tbl[18] = mk(0,1,1,0,32'h0,        0,1,0,0,0,32'h0);
    tbl[19] = mk(0,1,1,1,32'h34,       1,0,1,0,0,32'h34);
    tbl[20] = mk(0,1,1,0,32'h0,        0,0,0,0,0,32'h0);
    tbl[21] = mk(0,1,1,1,32'h35,       1,1,0,1,0,32'h35);
    tbl[22] = mk(0,0,0,1,32'h99,       0,1,0,0,0,32'h0);
    tbl[23] = mk(0,0,0,0,32'h0,        0,1,0,0,0,32'h0);
    for (int i = 0; i < 24; i++) apply(tbl[i]);

    // watchdog: m1 stalls for 8 BUSY cycles
    apply(mk(0,0,1,0,32'h0, 0,1,0,0,0,32'h0));
    for (int i = 0; i < 7; i++) apply(mk(0,0,1,0,32'h0, 1,1,0,0,0,32'h0));
    apply(mk(0,0,1,0,32'h0, 0,1,0,1,1,32'hDEADBEEF));
    apply(mk(0,0,0,0,32'h0, 0,1,0,0,0,32'h0));
    apply(mk(0,1,0,0,32'h0, 0,1,0,0,0,32'h0));
    apply(mk(0,1,0,1,32'h44, 1,0,1,0,0,32'h44));
    apply(mk(0,0,0,0,32'h0, 0,0,0,0,0,32'h0));

    // s_ready on the timeout cycle wins
    apply(mk(0,1,0,0,32'h0, 0,0,0,0,0,32'h0));
    for (int i = 0; i < 7; i++) apply(mk(0,1,0,0,32'h0, 1,0,0,0,0,32'h0));
    apply(mk(0,1,0,1,32'h55, 1,0,1,0,0,32'h55));
    apply(mk(0,0,0,0,32'h0, 0,0,0,0,0,32'h0));

    // granted master withdraws: silent abort
    apply(mk(0,1,0,0,32'h0, 0,0,0,0,0,32'h0));
    apply(mk(0,0,0,1,32'h77, 0,0,0,0,0,32'h0));
    apply(mk(0,0,0,0,32'h0, 0,0,0,0,0,32'h0));

    // reset while BUSY drops the transaction, fresh m1 request completes
    apply(mk(0,0,1,0,32'h0, 0,0,0,0,0,32'h0));
    apply(mk(1,0,1,0,32'h0, 1,1,0,0,0,32'h0));
    apply(mk(0,0,1,0,32'h0, 0,0,0,0,0,32'h0));
    apply(mk(0,0,1,1,32'h66, 1,1,0,1,0,32'h66));
    apply(mk(0,0,0,0,32'h0, 0,1,0,0,0,32'h0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
